// File: rtl/risc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// risc_cpu_pkg : shared fetch-state, width and opcode definitions
// Rev 1.0
// ============================================================================
package risc_cpu_pkg;

   localparam int ADDR_W = 13;
   localparam int OP_W   = 3;

   typedef logic [OP_W-1:0] opcode_t;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_RD_HI = 2'd1,
      FS_RD_LO = 2'd2,
      FS_HOLD  = 2'd3
   } fetch_state_e;

endpackage : risc_cpu_pkg
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_if : program-counter, program-memory and instruction handshake
// Rev 1.0
// ============================================================================
interface instr_fetch_if
   import risc_cpu_pkg::*;
#(
   parameter int ADDR_W = risc_cpu_pkg::ADDR_W
) ();

   logic [ADDR_W-1:0] pc_addr;
   logic              fetch_en;
   logic              flush;

   logic              mem_rd;
   logic [ADDR_W:0]   mem_addr;
   logic [7:0]        mem_rdata;
   logic              mem_ack;

   logic              ir_valid;
   logic              ir_ready;
   logic [15:0]       ir_data;
   opcode_t           opcode;
   logic [12:0]       ir_addr;

   logic              busy;
   logic              bus_err;

   // master is the fetch unit; slave is the controller/memory side
   modport master (
      input  pc_addr, fetch_en, flush, mem_rdata, mem_ack, ir_ready,
      output mem_rd, mem_addr, ir_valid, ir_data, opcode, ir_addr, busy, bus_err
   );

   modport slave (
      output pc_addr, fetch_en, flush, mem_rdata, mem_ack, ir_ready,
      input  mem_rd, mem_addr, ir_valid, ir_data, opcode, ir_addr, busy, bus_err
   );

endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/fetch_wdog.sv
`default_nettype none
// ============================================================================
// fetch_wdog : memory-read wait counter, flags the cycle the limit is reached
// Rev 1.0
// ============================================================================
module fetch_wdog #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [7:0] c_LAST = 8'(TIMEOUT_CYC - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 8'd0;
      end else if (clr) begin
         r_cnt <= 8'd0;
      end else if (inc) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // High on the unacknowledged cycle whose increment reaches TIMEOUT_CYC
   assign expired = inc && !clr && (r_cnt == c_LAST);

endmodule : fetch_wdog
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : fetches a 16-bit instruction as two byte reads, holds it
//               until the consumer accepts it
// Rev 1.0
// ============================================================================
module instr_fetch
   import risc_cpu_pkg::*;
#(
   parameter int ADDR_W      = risc_cpu_pkg::ADDR_W,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   localparam logic [1:0] c_ST_IDLE  = FS_IDLE;
   localparam logic [1:0] c_ST_RD_HI = FS_RD_HI;
   localparam logic [1:0] c_ST_RD_LO = FS_RD_LO;
   localparam logic [1:0] c_ST_HOLD  = FS_HOLD;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              w_take_pc;
   logic [ADDR_W-1:0] w_pc_sel;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [7:0]        r_hi_byte;

   logic              r_mem_rd;
   logic [ADDR_W:0]   r_mem_addr;
   logic              r_ir_valid;
   logic [15:0]       r_ir_data;
   logic              r_busy;
   logic              r_bus_err;

   logic              w_in_read;
   logic              w_wd_clr;
   logic              w_wd_inc;
   logic              w_wd_expired;

   assign w_in_read = (r_state == c_ST_RD_HI) || (r_state == c_ST_RD_LO);

   // Counter sits at zero outside reads and restarts after every ack,
   // so it is clear on entry to both RD_HI and RD_LO.
   assign w_wd_clr = !w_in_read || bus.mem_ack || bus.flush;
   assign w_wd_inc = w_in_read && !bus.mem_ack && !bus.flush;

   fetch_wdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_wd_clr),
      .inc     (w_wd_inc),
      .expired (w_wd_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_take_pc   = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            if (bus.fetch_en) begin
               w_state_nxt = c_ST_RD_HI;
               w_take_pc   = 1'b1;
            end
         end
         c_ST_RD_HI: begin
            if (bus.mem_ack) begin
               w_state_nxt = c_ST_RD_LO;
            end else if (w_wd_expired) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_RD_LO: begin
            if (bus.mem_ack) begin
               w_state_nxt = c_ST_HOLD;
            end else if (w_wd_expired) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_HOLD: begin
            if (bus.ir_ready) begin
               if (bus.fetch_en) begin
                  w_state_nxt = c_ST_RD_HI;
                  w_take_pc   = 1'b1;
               end else begin
                  w_state_nxt = c_ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
         end
      endcase
      // flush overrides fetch_en, ir_ready and any same-cycle ack
      if (bus.flush) begin
         w_state_nxt = c_ST_IDLE;
         w_take_pc   = 1'b0;
      end
   end

   assign w_pc_sel = w_take_pc ? bus.pc_addr : r_fetch_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_ST_IDLE;
         r_fetch_pc <= '0;
         r_hi_byte  <= 8'd0;
         r_mem_rd   <= 1'b0;
         r_mem_addr <= '0;
         r_ir_valid <= 1'b0;
         r_ir_data  <= 16'd0;
         r_busy     <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bus_err <= w_wd_expired;
         r_busy    <= (w_state_nxt != c_ST_IDLE);
         r_mem_rd  <= (w_state_nxt == c_ST_RD_HI) || (w_state_nxt == c_ST_RD_LO);
         r_ir_valid <= (w_state_nxt == c_ST_HOLD);

         if (w_take_pc) begin
            r_fetch_pc <= bus.pc_addr;
         end

         if (w_wd_expired) begin
            r_hi_byte <= 8'd0;
         end else if ((r_state == c_ST_RD_HI) && (w_state_nxt == c_ST_RD_LO)) begin
            r_hi_byte <= bus.mem_rdata;
         end

         if (w_state_nxt == c_ST_RD_HI) begin
            r_mem_addr <= {w_pc_sel, 1'b0};
         end else if (w_state_nxt == c_ST_RD_LO) begin
            r_mem_addr <= {r_fetch_pc, 1'b1};
         end

         if ((r_state == c_ST_RD_LO) && (w_state_nxt == c_ST_HOLD)) begin
            r_ir_data <= {r_hi_byte, bus.mem_rdata};
         end
      end
   end

   assign bus.mem_rd   = r_mem_rd;
   assign bus.mem_addr = r_mem_addr;
   assign bus.ir_valid = r_ir_valid;
   assign bus.ir_data  = r_ir_data;
   assign bus.opcode   = r_ir_data[15:13];
   assign bus.ir_addr  = r_ir_data[12:0];
   assign bus.busy     = r_busy;
   assign bus.bus_err  = r_bus_err;

endmodule : instr_fetch
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch
// Rev 1.0
// ============================================================================
module tb_instr_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int   wait_cfg = 0;
   bit   ack_en   = 1'b1;
   int   rd_cnt   = 0;
   logic [7:0] mem [0:255];

   instr_fetch_if #(.ADDR_W(13)) bus ();

   instr_fetch #(
      .ADDR_W      (13),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Byte memory: ack after wait_cfg idle request cycles
   always @(negedge clk) begin
      if (bus.mem_rd && ack_en) begin
         if (rd_cnt >= wait_cfg) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[7:0]];
            rd_cnt        = 0;
         end else begin
            bus.mem_ack   = 1'b0;
            rd_cnt        = rd_cnt + 1;
         end
      end else begin
         bus.mem_ack = 1'b0;
         rd_cnt      = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.fetch_en = 1'b1; bus.flush = 1'b1; bus.ir_ready = 1'b1;
      bus.pc_addr = 13'h1ABC;
      repeat (3) step();
      checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL reset ir_valid: got %b want 0", bus.ir_valid); end
      checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset mem_rd: got %b want 0", bus.mem_rd); end
      checks++; if (bus.mem_addr !== 14'h0000) begin errors++; $display("FAIL reset mem_addr: got %h want 0000", bus.mem_addr); end
      checks++; if (bus.ir_data !== 16'h0000) begin errors++; $display("FAIL reset ir_data: got %h want 0000", bus.ir_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
      checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset bus_err: got %b want 0", bus.bus_err); end
      rst = 1'b0; bus.fetch_en = 1'b0; bus.flush = 1'b0; bus.ir_ready = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_basic();
      bus.pc_addr = 13'h0005; bus.fetch_en = 1'b1;
      step();
      bus.fetch_en = 1'b0; bus.pc_addr = 13'h0155;
      checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL basic_hi mem_rd: got %b want 1", bus.mem_rd); end
      checks++; if (bus.mem_addr !== 14'h000A) begin errors++; $display("FAIL basic_hi mem_addr: got %h want 000a", bus.mem_addr); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_hi busy: got %b want 1", bus.busy); end
      checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL basic_hi ir_valid: got %b want 0", bus.ir_valid); end
      step();
      checks++; if (bus.mem_addr !== 14'h000B) begin errors++; $display("FAIL basic_lo mem_addr: got %h want 000b", bus.mem_addr); end
      checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL basic_lo ir_valid: got %b want 0", bus.ir_valid); end
      step();
      checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL basic_latency ir_valid: got %b want 1", bus.ir_valid); end
      checks++; if (bus.ir_data !== 16'hA012) begin errors++; $display("FAIL basic ir_data: got %h want a012", bus.ir_data); end
      checks++; if (bus.opcode !== 3'd5) begin errors++; $display("FAIL basic opcode: got %0d want 5", bus.opcode); end
      checks++; if (bus.ir_addr !== 13'h0012) begin errors++; $display("FAIL basic ir_addr: got %h want 0012", bus.ir_addr); end
      checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL basic_hold mem_rd: got %b want 0", bus.mem_rd); end
   endtask

   task automatic test_hold_stall();
      bus.fetch_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.pc_addr = 13'h0100 + 13'(i * 3);
         step();
         checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL stall%0d ir_valid: got %b want 1", i, bus.ir_valid); end
         checks++; if (bus.ir_data !== 16'hA012) begin errors++; $display("FAIL stall%0d ir_data: got %h want a012", i, bus.ir_data); end
         checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL stall%0d mem_rd: got %b want 0", i, bus.mem_rd); end
      end
      bus.fetch_en = 1'b0; bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL stall_accept ir_valid: got %b want 0", bus.ir_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_accept busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_wait_states();
      logic [13:0] exp_addr;
      wait_cfg = 3;
      bus.pc_addr = 13'h0020; bus.fetch_en = 1'b1;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         step();
         bus.fetch_en = 1'b0; bus.pc_addr = 13'h0777;
         if (cyc < 9) begin
            exp_addr = (cyc <= 4) ? 14'h0040 : 14'h0041;
            checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL wait_c%0d mem_rd: got %b want 1", cyc, bus.mem_rd); end
            checks++; if (bus.mem_addr !== exp_addr) begin errors++; $display("FAIL wait_c%0d mem_addr: got %h want %h", cyc, bus.mem_addr, exp_addr); end
            checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL wait_c%0d ir_valid: got %b want 0", cyc, bus.ir_valid); end
         end else begin
            checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL wait_latency ir_valid: got %b want 1", bus.ir_valid); end
            checks++; if (bus.ir_data !== 16'h7C7D) begin errors++; $display("FAIL wait ir_data: got %h want 7c7d", bus.ir_data); end
         end
      end
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
      wait_cfg = 0;
   endtask

   task automatic test_flush_ack();
      bus.pc_addr = 13'h0007; bus.fetch_en = 1'b1;
      step();
      bus.fetch_en = 1'b0;
      checks++; if (bus.mem_addr !== 14'h000E) begin errors++; $display("FAIL flush_hi mem_addr: got %h want 000e", bus.mem_addr); end
      step();
      checks++; if (bus.mem_addr !== 14'h000F) begin errors++; $display("FAIL flush_lo mem_addr: got %h want 000f", bus.mem_addr); end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL flush mem_rd: got %b want 0", bus.mem_rd); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush busy: got %b want 0", bus.busy); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL flush_c%0d ir_valid: got %b want 0", i, bus.ir_valid); end
         step();
      end
   endtask

   task automatic test_timeout();
      ack_en = 1'b0;
      bus.pc_addr = 13'h0100; bus.fetch_en = 1'b1;
      for (int cyc = 1; cyc <= 17; cyc++) begin
         step();
         bus.fetch_en = 1'b0;
         if (cyc <= 15) begin
            checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL tmo_c%0d bus_err: got %b want 0", cyc, bus.bus_err); end
            checks++; if (bus.mem_addr !== 14'h0200) begin errors++; $display("FAIL tmo_c%0d mem_addr: got %h want 0200", cyc, bus.mem_addr); end
            checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL tmo_c%0d mem_rd: got %b want 1", cyc, bus.mem_rd); end
         end else if (cyc == 16) begin
            checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse bus_err: got %b want 1", bus.bus_err); end
            checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL tmo_pulse mem_rd: got %b want 0", bus.mem_rd); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_pulse busy: got %b want 0", bus.busy); end
         end else begin
            checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL tmo_end bus_err: got %b want 0", bus.bus_err); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL tmo_end busy: got %b want 0", bus.busy); end
         end
      end
      ack_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      bus.pc_addr = 13'h0005; bus.fetch_en = 1'b1;
      step();
      bus.fetch_en = 1'b0;
      step();
      step();
      checks++; if (bus.ir_data !== 16'hA012) begin errors++; $display("FAIL b2b_first ir_data: got %h want a012", bus.ir_data); end
      bus.ir_ready = 1'b1; bus.fetch_en = 1'b1; bus.pc_addr = 13'h0006;
      step();
      bus.ir_ready = 1'b0; bus.fetch_en = 1'b0; bus.pc_addr = 13'h1FFF;
      checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL b2b_hi mem_rd: got %b want 1", bus.mem_rd); end
      checks++; if (bus.mem_addr !== 14'h000C) begin errors++; $display("FAIL b2b_hi mem_addr: got %h want 000c", bus.mem_addr); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_hi busy: got %b want 1", bus.busy); end
      checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL b2b_hi ir_valid: got %b want 0", bus.ir_valid); end
      step();
      checks++; if (bus.mem_addr !== 14'h000D) begin errors++; $display("FAIL b2b_lo mem_addr: got %h want 000d", bus.mem_addr); end
      step();
      checks++; if (bus.ir_valid !== 1'b1) begin errors++; $display("FAIL b2b ir_valid: got %b want 1", bus.ir_valid); end
      checks++; if (bus.ir_data !== 16'h3031) begin errors++; $display("FAIL b2b ir_data: got %h want 3031", bus.ir_data); end
      checks++; if (bus.opcode !== 3'd1) begin errors++; $display("FAIL b2b opcode: got %0d want 1", bus.opcode); end
      checks++; if (bus.ir_addr !== 13'h1031) begin errors++; $display("FAIL b2b ir_addr: got %h want 1031", bus.ir_addr); end
      bus.ir_ready = 1'b1;
      step();
      bus.ir_ready = 1'b0;
   endtask

   task automatic test_flush_priority();
      bus.pc_addr = 13'h0002; bus.fetch_en = 1'b1;
      step();
      bus.fetch_en = 1'b0;
      step();
      step();
      checks++; if (bus.ir_data !== 16'h3839) begin errors++; $display("FAIL fprio ir_data: got %h want 3839", bus.ir_data); end
      bus.flush = 1'b1; bus.ir_ready = 1'b1; bus.fetch_en = 1'b1; bus.pc_addr = 13'h0009;
      step();
      bus.flush = 1'b0; bus.ir_ready = 1'b0; bus.fetch_en = 1'b0;
      checks++; if (bus.ir_valid !== 1'b0) begin errors++; $display("FAIL fprio ir_valid: got %b want 0", bus.ir_valid); end
      checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL fprio mem_rd: got %b want 0", bus.mem_rd); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fprio busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_reset_mid_read();
      ack_en = 1'b0;
      bus.pc_addr = 13'h0003; bus.fetch_en = 1'b1;
      step();
      bus.fetch_en = 1'b0;
      checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL rstmid_pre mem_rd: got %b want 1", bus.mem_rd); end
      step();
      rst = 1'b1; bus.flush = 1'b1;
      step();
      rst = 1'b0; bus.flush = 1'b0;
      checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL rstmid mem_rd: got %b want 0", bus.mem_rd); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b want 0", bus.busy); end
      checks++; if (bus.mem_addr !== 14'h0000) begin errors++; $display("FAIL rstmid mem_addr: got %h want 0000", bus.mem_addr); end
      checks++; if (bus.ir_data !== 16'h0000) begin errors++; $display("FAIL rstmid ir_data: got %h want 0000", bus.ir_data); end
      ack_en = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'(i) ^ 8'h3C;
      end
      mem[8'h0A] = 8'hA0;
      mem[8'h0B] = 8'h12;
      bus.pc_addr  = '0;
      bus.fetch_en = 1'b0;
      bus.flush    = 1'b0;
      bus.ir_ready = 1'b0;

      test_reset();
      test_basic();
      test_hold_stall();
      test_wait_states();
      test_flush_ack();
      test_timeout();
      test_back_to_back();
      test_flush_priority();
      test_reset_mid_read();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule : tb_instr_fetch
`default_nettype wire
